// File: rtl/sub_wave_pkg.sv
// Shared types and constants for the waveform-sample generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: ramp FSM state enum, LFSR tap mask and step function, ramp endpoint.

package sub_wave_pkg;

   // Ramp FSM state encoding; the numeric values are visible on the state output.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_HOLD = 2'd2,
      ST_DOWN = 2'd3
   } ramp_state_e;

   // Feedback taps for x^16+x^14+x^13+x^11+1 in a shift-left Fibonacci LFSR:
   // bits 15, 13, 12 and 10 of the current value.
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam logic [7:0] RAMP_MAX = 8'hFF;

   // One LFSR step: shift left, new LSB is the XOR of the tapped bits.
   function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
      return {cur[14:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/sub_wave_lfsr.sv
// 16-bit maximal-length Fibonacci LFSR with a reset seed.
// Latency: value advances one step per clock; output is the state register.
// Backpressure: none, free-running.
// Ports: clk_i clock, rst_i sync active-high reset, lfsr_o current LFSR value.

module sub_wave_lfsr
   import sub_wave_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [15:0] lfsr_o
);

   // All-zero is the lock-up state of an XOR LFSR, so a zero seed is replaced.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_next(lfsr_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q <= SEED_EFF;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sub_wave_gen.sv
// Self-running waveform-sample generator: counter, clock taps, LFSR, strobe, triangle ramp.
// Latency: all outputs are registers except wrap_o, which decodes the counter register.
// Backpressure: none; no inputs other than clock and reset, output depends only on cycles since reset.
// Ports: clk_i, rst_i (sync, active high); count_o/wrap_o counter and all-ones flag;
//        div2_o/div4_o/div8_o counter bits 0..2; lfsr_o 16-bit LFSR; pulse_o periodic strobe;
//        state_o ramp FSM state; ramp_o 8-bit triangle.

module sub_wave_gen
   import sub_wave_pkg::*;
#(
   parameter int          CNT_WIDTH    = 16,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1,
   parameter int          PULSE_PERIOD = 10,
   parameter int          HOLD_CYCLES  = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic [CNT_WIDTH-1:0] count_o,
   output logic                 wrap_o,
   output logic                 div2_o,
   output logic                 div4_o,
   output logic                 div8_o,
   output logic [15:0]          lfsr_o,
   output logic                 pulse_o,
   output logic [1:0]           state_o,
   output logic [7:0]           ramp_o
);

   localparam logic [15:0] PULSE_LAST = 16'(PULSE_PERIOD - 1);
   localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_CYCLES - 1);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;
   logic [15:0]          pcnt_q;
   logic [15:0]          pcnt_d;
   logic                 pulse_q;
   ramp_state_e          state_q;
   logic [7:0]           ramp_q;
   logic [7:0]           hold_q;

   // Free-running counter and strobe phase counter.
   always_comb begin
      count_d = count_q + 1'b1;
      pcnt_d  = (pcnt_q == PULSE_LAST) ? 16'd0 : pcnt_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         pcnt_q  <= '0;
         pulse_q <= 1'b0;
      end else begin
         count_q <= count_d;
         pcnt_q  <= pcnt_d;
         // Strobe is registered: high in the cycle after the phase counter hits its last value.
         pulse_q <= (pcnt_q == PULSE_LAST);
      end
   end

   // Triangle ramp FSM. Endpoints are tested before stepping so the ramp never wraps.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ramp_q  <= 8'd0;
         hold_q  <= 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_q <= ST_UP;
            end
            ST_UP: begin
               if (ramp_q == RAMP_MAX) begin
                  state_q <= ST_HOLD;
                  hold_q  <= 8'd0;
               end else begin
                  ramp_q <= ramp_q + 8'd1;
               end
            end
            ST_HOLD: begin
               hold_q <= hold_q + 8'd1;
               if (hold_q == HOLD_LAST) begin
                  state_q <= ST_DOWN;
               end
            end
            ST_DOWN: begin
               if (ramp_q == 8'd0) begin
                  state_q <= ST_UP;
               end else begin
                  ramp_q <= ramp_q - 8'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   sub_wave_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .lfsr_o (lfsr_o)
   );

   assign count_o = count_q;
   assign wrap_o  = (count_q == {CNT_WIDTH{1'b1}});
   assign div2_o  = count_q[0];
   assign div4_o  = count_q[1];
   assign div8_o  = count_q[2];
   assign pulse_o = pulse_q;
   assign state_o = state_q;
   assign ramp_o  = ramp_q;

endmodule

// File: tb/tb_sub_wave_gen.sv
// Directed bench for sub_wave_gen: default instance (a) and overridden instance (b).
// Latency: n/a.
// Backpressure: n/a.

module tb_sub_wave_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   logic [15:0] count_a, count_b;
   logic        wrap_a, wrap_b;
   logic        d2_a, d4_a, d8_a, d2_b, d4_b, d8_b;
   logic [15:0] lfsr_a, lfsr_b;
   logic        pulse_a, pulse_b;
   logic [1:0]  state_a, state_b;
   logic [7:0]  ramp_a, ramp_b;

   sub_wave_gen u_dut_a (
      .clk_i   (clk),
      .rst_i   (rst),
      .count_o (count_a),
      .wrap_o  (wrap_a),
      .div2_o  (d2_a),
      .div4_o  (d4_a),
      .div8_o  (d8_a),
      .lfsr_o  (lfsr_a),
      .pulse_o (pulse_a),
      .state_o (state_a),
      .ramp_o  (ramp_a)
   );

   sub_wave_gen #(
      .LFSR_SEED    (16'h0000),
      .PULSE_PERIOD (2),
      .HOLD_CYCLES  (1)
   ) u_dut_b (
      .clk_i   (clk),
      .rst_i   (rst),
      .count_o (count_b),
      .wrap_o  (wrap_b),
      .div2_o  (d2_b),
      .div4_o  (d4_b),
      .div8_o  (d8_b),
      .lfsr_o  (lfsr_b),
      .pulse_o (pulse_b),
      .state_o (state_b),
      .ramp_o  (ramp_b)
   );

   int n_checks = 0;
   int n_errors = 0;
   int k = 0;          // clock edges since reset release
   int first_ret = 0;  // first k>0 where lfsr_a returned to its seed
   bit zero_seen = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      k = 0;
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // Reset state
      check_eq("rst_count", 32'(count_a), 32'h0);
      check_eq("rst_wrap", 32'(wrap_a), 32'h0);
      check_eq("rst_lfsr", 32'(lfsr_a), 32'hACE1);
      check_eq("rst_state", 32'(state_a), 32'h0);
      check_eq("rst_ramp", 32'(ramp_a), 32'h0);
      check_eq("rst_pulse", 32'(pulse_a), 32'h0);
      check_eq("rst_divs", {29'd0, d8_a, d4_a, d2_a}, 32'h0);
      check_eq("b_rst_lfsr", 32'(lfsr_b), 32'h0001);
      check_eq("b_rst_pulse", 32'(pulse_b), 32'h0);

      // First 20 cycles: counter, taps, strobe
      for (int i = 1; i <= 20; i++) begin
         logic [31:0] iv;
         iv = 32'(i);
         tick();
         if (i == 1) begin
            check_eq("k1_lfsr", 32'(lfsr_a), 32'h59C3);
            check_eq("k1_state", 32'(state_a), 32'h1);
            check_eq("k1_ramp", 32'(ramp_a), 32'h0);
            check_eq("b_k1_lfsr", 32'(lfsr_b), 32'h0002);
         end
         check_eq("count", 32'(count_a), iv);
         check_eq("div2", 32'(d2_a), 32'(iv[0]));
         check_eq("div4", 32'(d4_a), 32'(iv[1]));
         check_eq("div8", 32'(d8_a), 32'(iv[2]));
         check_eq("wrap_low", 32'(wrap_a), 32'h0);
         check_eq("pulse", 32'(pulse_a), (i == 10 || i == 20) ? 32'h1 : 32'h0);
         check_eq("b_pulse", 32'(pulse_b), (i % 2 == 0) ? 32'h1 : 32'h0);
      end

      // Triangle top and hold
      while (k < 256) tick();
      check_eq("k256_ramp", 32'(ramp_a), 32'd255);
      check_eq("k256_state", 32'(state_a), 32'h1);
      tick(); // 257
      check_eq("k257_state", 32'(state_a), 32'h2);
      check_eq("k257_ramp", 32'(ramp_a), 32'd255);
      check_eq("b_k257_state", 32'(state_b), 32'h2);
      tick(); // 258
      check_eq("k258_state", 32'(state_a), 32'h2);
      check_eq("b_k258_state", 32'(state_b), 32'h3);
      check_eq("b_k258_ramp", 32'(ramp_b), 32'd255);
      tick(); // 259
      check_eq("b_k259_ramp", 32'(ramp_b), 32'd254);
      tick(); // 260
      check_eq("k260_state", 32'(state_a), 32'h2);
      tick(); // 261
      check_eq("k261_state", 32'(state_a), 32'h3);
      check_eq("k261_ramp", 32'(ramp_a), 32'd255);
      tick(); // 262
      check_eq("k262_ramp", 32'(ramp_a), 32'd254);

      // Bottom of the triangle and restart of the climb
      while (k < 516) tick();
      check_eq("k516_ramp", 32'(ramp_a), 32'd0);
      check_eq("k516_state", 32'(state_a), 32'h3);
      tick(); // 517
      check_eq("k517_state", 32'(state_a), 32'h1);
      check_eq("k517_ramp", 32'(ramp_a), 32'd0);
      tick(); // 518
      check_eq("k518_ramp", 32'(ramp_a), 32'd1);

      // One period later, mid-DOWN at ramp 100
      while (k < 932) tick();
      check_eq("k932_state", 32'(state_a), 32'h3);
      check_eq("k932_ramp", 32'(ramp_a), 32'd100);

      // Mid-operation reset
      do_reset();
      check_eq("mid_rst_ramp", 32'(ramp_a), 32'h0);
      check_eq("mid_rst_state", 32'(state_a), 32'h0);
      check_eq("mid_rst_count", 32'(count_a), 32'h0);
      check_eq("mid_rst_lfsr", 32'(lfsr_a), 32'hACE1);
      check_eq("mid_rst_pulse", 32'(pulse_a), 32'h0);
      while (k < 9) tick();
      check_eq("mid_k9_pulse", 32'(pulse_a), 32'h0);
      tick();
      check_eq("mid_k10_pulse", 32'(pulse_a), 32'h1);

      // Long free run to the counter wrap and the LFSR period
      while (k < 65535) begin
         tick();
         if (lfsr_a == 16'h0000) zero_seen = 1'b1;
         if (lfsr_a == 16'hACE1 && first_ret == 0) first_ret = k;
         if (k == 65534) check_eq("k65534_wrap", 32'(wrap_a), 32'h0);
      end
      check_eq("k65535_count", 32'(count_a), 32'hFFFF);
      check_eq("k65535_wrap", 32'(wrap_a), 32'h1);
      check_eq("k65535_lfsr", 32'(lfsr_a), 32'hACE1);
      check_eq("lfsr_period", 32'(first_ret), 32'd65535);
      check_eq("lfsr_zero_seen", 32'(zero_seen), 32'h0);
      check_eq("b_k65535_lfsr", 32'(lfsr_b), 32'h0001);
      tick(); // 65536
      check_eq("k65536_count", 32'(count_a), 32'h0);
      check_eq("k65536_wrap", 32'(wrap_a), 32'h0);
      check_eq("k65536_lfsr", 32'(lfsr_a), 32'h59C3);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
